// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester ids and the default memory depth.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    localparam int DMEM_DEPTH = 256;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the parent owns the
// last_grant history bit and decides when arbitration is enabled.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            // On contention the port that did not win last time goes first.
            if (valid == 2'b11) begin
                grant = (last_grant == PORT_DMA) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// DMA/debug master (port 1), one transaction in flight at a time.
// Optional address bounds check enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [1:0]          grant;
    logic                arb_en;
    logic                cmd_oob;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    logic                err_q, err_d;
`endif

    assign arb_en  = (state_q == IDLE);
    assign cmd_oob = BOUNDS_EN && (cmd_addr_q >= ADDR_W'(DEPTH));

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|grant) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        err_d        = err_q;
`endif
        if (|grant) begin
            last_grant_d = grant[1];
            owner_d      = grant[1];
            cmd_wr_d     = grant[1] ? req1_wr    : req0_wr;
            cmd_addr_d   = grant[1] ? req1_addr  : req0_addr;
            cmd_wdata_d  = grant[1] ? req1_wdata : req0_wdata;
        end
        // Memory read data is sampled at the end of ACCESS; for a write this
        // is the word as it was before the write lands.
        if (state_q == ACCESS) begin
            if (owner_q == PORT_DMA) begin
                rdata1_d = cmd_oob ? '0 : mem_rdata;
            end else begin
                rdata0_d = cmd_oob ? '0 : mem_rdata;
            end
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            err_d = cmd_oob;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_DMA;
            owner_q      <= PORT_CORE;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cmd_wr_q     <= cmd_wr_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    // Memory address/data come straight from the latched command so they never
    // follow the request inputs; write enable is only live during ACCESS.
    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        rsp0_valid = (state_q == RESP) && (owner_q == PORT_CORE);
        rsp1_valid = (state_q == RESP) && (owner_q == PORT_DMA);
        rsp0_rdata = rdata0_q;
        rsp1_rdata = rdata1_q;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
`else
        rsp0_err   = 1'b0;
        rsp1_err   = 1'b0;
`endif
        mem_addr   = cmd_addr_q;
        mem_wdata  = cmd_wdata_q;
        mem_wr     = (state_q == ACCESS) && cmd_wr_q && !cmd_oob;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests on both ports against a small
// behavioural memory, responses checked by a scoreboard monitor.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_wr;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_wr;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    logic        prev0 = 1'b0;
    logic        prev1 = 1'b0;
    logic [31:0] mem [0:511];

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (mem_wr) begin
            mem[mem_addr[8:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] rd, input logic er);
        exp_t x;
        x.port = p;
        x.rdata = rd;
        x.err = er;
        sb.push_back(x);
    endtask

    task automatic drive(input int p, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
        chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
        chk({tag, "_rsp0_err"}, rsp0_err, 0);
        chk({tag, "_rsp1_err"}, rsp1_err, 0);
        chk({tag, "_rsp0_rdata"}, rsp0_rdata, 0);
        chk({tag, "_rsp1_rdata"}, rsp1_rdata, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Single uncontended transaction: accept at N, access at N+1, response at N+2.
    task automatic txn(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_memwr);
        int n;
        bit got;
        @(posedge clk); #1;
        drive(p, 1'b1, wr, a, d);
        got = 0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) got = 1;
            else begin
                n++;
                @(posedge clk); #1;
            end
        end
        chk("txn_accept", got, 1);
        if (got) begin
            chk("txn_memwr_idle", mem_wr, 0);
            push(p, e_rdata, e_err);
            @(posedge clk); #1;
            drive(p, 1'b0, 1'b0, a, d);
            @(negedge clk);
            chk("txn_memwr_access", mem_wr, e_memwr);
            chk("txn_memaddr_access", mem_addr, a);
            if (wr) chk("txn_memwdata_access", mem_wdata, d);
            chk("txn_ready_access", {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("txn_rsp_timing", (p == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("txn_memwr_resp", mem_wr, 0);
        end
    endtask

    // Both ports request reads together; the two grants must alternate from 'first'.
    task automatic contend(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] e0, input logic [31:0] e1, input int first);
        int w;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, a0, 0);
        drive(1, 1'b1, 1'b0, a1, 0);
        for (int g = 0; g < 2; g++) begin
            w = (g == 0) ? first : 1 - first;
            @(negedge clk);
            chk("grant_p0", req0_ready, (w == 0));
            chk("grant_p1", req1_ready, (w == 1));
            if (req0_ready) push(0, e0, 1'b0);
            else if (req1_ready) push(1, e1, 1'b0);
            @(posedge clk); #1;
            if (w == 0) drive(0, 1'b0, 1'b0, a0, 0);
            else drive(1, 1'b0, 1'b0, a1, 0);
            @(negedge clk);
            chk("loser_wait_access", {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("loser_wait_resp", {req1_ready, req0_ready}, 0);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b expected no response",
                         rsp0_valid, rsp1_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner_valid", (e.port == 0) ? rsp0_valid : rsp1_valid, 1);
                chk("rsp_other_valid", (e.port == 0) ? rsp1_valid : rsp0_valid, 0);
                chk("rsp_rdata", (e.port == 0) ? rsp0_rdata : rsp1_rdata, e.rdata);
                chk("rsp_err", (e.port == 0) ? rsp0_err : rsp1_err, e.err);
            end
            if (rsp0_valid) chk("rsp0_pulse_width", prev0, 0);
            if (rsp1_valid) chk("rsp1_pulse_width", prev1, 0);
        end
        prev0 = rsp0_valid;
        prev1 = rsp1_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);
        #2;
        chk_reset("init");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Contention straight after reset: 0,1 then 0,1 again.
        contend(32'd5, 32'd6, 32'h0, 32'h0, 0);
        contend(32'd5, 32'd6, 32'h0, 32'h0, 0);

        // Write then read back on port 0.
        txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        txn(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Port 1 holds valid continuously: granted every third cycle.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'd5, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("hold_ready1", req1_ready, (i % 3 == 0));
            chk("hold_rsp1_valid", rsp1_valid, (i % 3 == 2));
            if (req1_ready) push(1, 32'hDEADBEEF, 1'b0);
            if (i < 8) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd5, 0);
        chk("rsp0_rdata_hold", rsp0_rdata, 32'hDEADBEEF);

        // Port 0 payload wanders while port 1 owns the memory.
        @(negedge clk);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'd6, 0);
        @(negedge clk);
        chk("pl_ready1", req1_ready, 1);
        push(1, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd6, 0);
        drive(0, 1'b1, 1'b1, 32'd7, 32'hBAD0BAD0);
        @(negedge clk);
        chk("pl_ready0_access", req0_ready, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'd8, 32'hBAD1BAD1);
        @(negedge clk);
        chk("pl_ready0_resp", req0_ready, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        chk("pl_ready0_idle", req0_ready, 1);
        push(0, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd5, 0);
        @(negedge clk);
        chk("pl_memwr", mem_wr, 0);
        chk("pl_memaddr", mem_addr, 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        txn(0, 1'b0, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        txn(0, 1'b0, 32'd8, 32'h0, 32'h0, 1'b0, 1'b0);

        // Out-of-range address 300.
        txn(0, 1'b1, 32'd300, 32'hCAFEF00D, 32'h0, BC, !BC);
        txn(0, 1'b0, 32'd300, 32'h0, BC ? 32'h0 : 32'hCAFEF00D, BC, 1'b0);

        // Reset lands during the ACCESS of a port 1 write.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'd9, 32'h12345678);
        @(negedge clk);
        chk("abort_ready1", req1_ready, 1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'h0);
        chk("abort_memwr_access", mem_wr, 1);
        chk("abort_memaddr_access", mem_addr, 32'd9);
        #2 rst = 1'b0;
        #1;
        chk("abort_memwr_async", mem_wr, 0);
        chk_reset("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp1", rsp1_valid, 0);
        end
        txn(1, 1'b0, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
